// File: rtl/bitty_exec_pkg.sv
// Shared types and instruction-field layout for the Bitty execute unit.
package bitty_exec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    STORE,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ADD,
    SUB,
    AND,
    OR,
    XOR,
    SHL,
    SHR,
    CMP
  } sel_t;

  localparam logic [1:0] FMT_REG = 2'd0;
  localparam logic [1:0] FMT_IMM = 2'd1;

  // Bit positions inside the 16-bit instruction word.
  localparam int unsigned RX_LSB  = 13;
  localparam int unsigned RY_LSB  = 10;
  localparam int unsigned IMM_LSB = 5;
  localparam int unsigned SEL_LSB = 2;
  localparam int unsigned FMT_LSB = 0;

  // Formats 2 and 3 are reserved.
  function automatic logic fmt_illegal(input logic [1:0] fmt);
    return fmt[1];
  endfunction

endpackage

// File: rtl/bitty_alu_p.sv
// Width-generic combinational ALU; carry is only meaningful for ADD/SUB.
module bitty_alu_p
  import bitty_exec_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  sel_t              sel,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam logic [DATA_W-1:0] W_MOD = DATA_W'(DATA_W);

  logic [DATA_W-1:0] shamt;
  logic [DATA_W:0]   sum;

  // Operation select; shift distance wraps modulo the data width.
  always_comb begin
    shamt  = b % W_MOD;
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    unique case (sel)
      ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      AND: result = a & b;
      OR:  result = a | b;
      XOR: result = a ^ b;
      SHL: result = a << shamt;
      SHR: result = a >> shamt;
      CMP: begin
        if (a == b)     result = '0;
        else if (a > b) result = DATA_W'(1);
        else            result = DATA_W'(2);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/bitty_exec_unit.sv
// Multi-cycle Bitty execute unit: handshake, register file, FSM and writeback.
module bitty_exec_unit
  import bitty_exec_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              stall,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] d_out,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  if (NREGS != 8) begin : g_nregs_check
    $error("bitty_exec_unit: NREGS must be 8 (3-bit register fields)");
  end
  if (DATA_W < 8 || DATA_W > 64) begin : g_width_check
    $error("bitty_exec_unit: DATA_W must be within 8..64");
  end

  state_t            state, state_next;
  logic [15:0]       reg_i;
  logic [DATA_W-1:0] reg_a, reg_b, reg_c;
  logic [DATA_W-1:0] regs [NREGS];

  logic [2:0]        rx, ry;
  logic [7:0]        imm8;
  logic [1:0]        fmt;
  logic              illegal;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  assign rx      = reg_i[RX_LSB +: 3];
  assign ry      = reg_i[RY_LSB +: 3];
  assign imm8    = reg_i[IMM_LSB +: 8];
  assign fmt     = reg_i[FMT_LSB +: 2];
  assign illegal = fmt_illegal(fmt);

  bitty_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a      (reg_a),
    .b      (reg_b),
    .sel    (sel_t'(reg_i[SEL_LSB +: 3])),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: stall freezes DECODE and EXEC only.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (instr_valid) state_next = DECODE;
      DECODE:  if (!stall) state_next = EXEC;
      EXEC:    if (!stall) state_next = STORE;
      STORE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: instruction capture, operand fetch, result/flag latch, writeback.
  // Operand and result latches re-run every stalled cycle; inputs are stable
  // until STORE so the repeated load is harmless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_i  <= '0;
      reg_a  <= '0;
      reg_b  <= '0;
      reg_c  <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        IDLE: if (instr_valid) reg_i <= instr;
        DECODE: begin
          reg_a <= regs[rx];
          reg_b <= (fmt == FMT_IMM) ? DATA_W'(imm8) : regs[ry];
        end
        EXEC: begin
          if (illegal) begin
            reg_c  <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
          end else begin
            reg_c  <= alu_result;
            flag_z <= (alu_result == '0);
            flag_c <= alu_carry;
          end
        end
        STORE: if (!illegal) regs[rx] <= reg_c;
        default: ;
      endcase
    end
  end

  assign instr_ready = (state == IDLE);
  assign done        = (state == DONE);
  assign err         = (state == DONE) && illegal;
  assign d_out       = reg_c;
  assign dbg_data    = regs[dbg_addr];

endmodule

// File: tb/tb_bitty_exec_unit.sv
// Directed, table-driven bench for bitty_exec_unit at DATA_W=16.
module tb_bitty_exec_unit;
  import bitty_exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        done;
  logic        err;
  logic [15:0] d_out;
  logic        flag_z;
  logic        flag_c;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int errors = 0;
  int checks = 0;

  bitty_exec_unit #(.DATA_W(16), .NREGS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .stall       (stall),
    .done        (done),
    .err         (err),
    .d_out       (d_out),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] ins;
    logic [15:0] d;
    logic        z;
    logic        c;
    logic        e;
    logic [2:0]  rx;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] e_imm(input logic [2:0] rx, input logic [7:0] imm,
                                        input logic [2:0] sel);
    return {rx, imm, sel, 2'b01};
  endfunction

  function automatic logic [15:0] e_reg(input logic [2:0] rx, input logic [2:0] ry,
                                        input logic [2:0] sel);
    return {rx, ry, 5'b00000, sel, 2'b00};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Handshake one instruction, then count edges until done (bounded).
  task automatic issue(input logic [15:0] ins, output int lat);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = 16'hFFFF;
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_done(inout int lat);
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic leave_done(input string tag);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, done, 1'b0);
    check({tag, " ready after"}, instr_ready, 1'b1);
  endtask

  logic [15:0] v;
  int          lat;
  int          seen;

  initial begin
    reset       = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    stall       = 1'b0;
    dbg_addr    = '0;

    vecs.push_back('{16'h20A1, 16'h0005, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0005});
    vecs.push_back('{16'h4061, 16'h0003, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0003});
    vecs.push_back('{16'h2800, 16'h0008, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0008});
    vecs.push_back('{16'h4404, 16'hFFFB, 1'b0, 1'b1, 1'b0, 3'd2, 16'hFFFB});
    vecs.push_back('{16'h281C, 16'h0002, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0002});
    vecs.push_back('{16'h20A2, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0002});
    vecs.push_back('{e_reg(3'd2, 3'd2, ADD),     16'hFFF6, 1'b0, 1'b1, 1'b0, 3'd2, 16'hFFF6});
    vecs.push_back('{e_imm(3'd3, 8'hFF, ADD),    16'h00FF, 1'b0, 1'b0, 1'b0, 3'd3, 16'h00FF});
    vecs.push_back('{e_imm(3'd3, 8'd4, SHL),     16'h0FF0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h0FF0});
    vecs.push_back('{e_imm(3'd3, 8'd20, SHR),    16'h00FF, 1'b0, 1'b0, 1'b0, 3'd3, 16'h00FF});
    vecs.push_back('{e_reg(3'd4, 3'd3, OR),      16'h00FF, 1'b0, 1'b0, 1'b0, 3'd4, 16'h00FF});
    vecs.push_back('{e_reg(3'd4, 3'd2, AND),     16'h00F6, 1'b0, 1'b0, 1'b0, 3'd4, 16'h00F6});
    vecs.push_back('{e_reg(3'd4, 3'd4, XOR),     16'h0000, 1'b1, 1'b0, 1'b0, 3'd4, 16'h0000});
    vecs.push_back('{e_reg(3'd3, 3'd4, CMP),     16'h0001, 1'b0, 1'b0, 1'b0, 3'd3, 16'h0001});
    vecs.push_back('{e_reg(3'd3, 3'd3, CMP),     16'h0000, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0000});
    vecs.push_back('{e_reg(3'd5, 3'd2, SUB),     16'h000A, 1'b0, 1'b1, 1'b0, 3'd5, 16'h000A});
    vecs.push_back('{e_imm(3'd2, 8'd10, ADD),    16'h0000, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0000});
    vecs.push_back('{{3'd5, 8'h55, 3'd0, 2'b11}, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd5, 16'h000A});
    vecs.push_back('{e_imm(3'd5, 8'd17, SHL),    16'h0014, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0014});
    vecs.push_back('{e_reg(3'd5, 3'd5, SUB),     16'h0000, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0000});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst instr_ready", instr_ready, 1'b1);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst d_out", d_out, 16'h0);
    check("rst flag_z", flag_z, 1'b0);
    check("rst flag_c", flag_c, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      check($sformatf("rst R%0d", i), v, 16'h0);
    end

    // Table-driven instruction stream.
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].ins, lat);
      check($sformatf("v%0d latency", i), lat, 3);
      check($sformatf("v%0d err", i), err, vecs[i].e);
      check($sformatf("v%0d d_out", i), d_out, vecs[i].d);
      check($sformatf("v%0d flag_z", i), flag_z, vecs[i].z);
      check($sformatf("v%0d flag_c", i), flag_c, vecs[i].c);
      read_reg(vecs[i].rx, v);
      check($sformatf("v%0d R%0d", i, vecs[i].rx), v, vecs[i].r);
      leave_done($sformatf("v%0d", i));
    end

    // Stall held for 3 cycles in DECODE, busy-time instr_valid ignored.
    instr       = e_imm(3'd5, 8'h2A, ADD);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    stall = 1'b1;
    instr = e_imm(3'd1, 8'h77, ADD);
    lat = 0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall ready %0d", k), instr_ready, 1'b0);
      check($sformatf("stall done %0d", k), done, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    stall       = 1'b0;
    instr_valid = 1'b0;
    wait_done(lat);
    check("stall latency", lat, 6);
    check("stall d_out", d_out, 16'h002A);
    read_reg(3'd5, v);
    check("stall R5", v, 16'h002A);
    read_reg(3'd1, v);
    check("stall R1 untouched", v, 16'h0002);
    leave_done("stall");

    // Stall held for 2 cycles in EXEC.
    instr       = e_reg(3'd5, 3'd5, ADD);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    lat++;
    stall = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      lat++;
    end
    check("xstall ready", instr_ready, 1'b0);
    stall = 1'b0;
    wait_done(lat);
    check("xstall latency", lat, 5);
    check("xstall d_out", d_out, 16'h0054);
    check("xstall flag_c", flag_c, 1'b0);
    read_reg(3'd5, v);
    check("xstall R5", v, 16'h0054);
    leave_done("xstall");

    // Asynchronous reset while in STORE.
    instr       = 16'h20A1;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("arst ready", instr_ready, 1'b1);
    check("arst done", done, 1'b0);
    check("arst d_out", d_out, 16'h0);
    check("arst flag_z", flag_z, 1'b0);
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      check($sformatf("arst R%0d", i), v, 16'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("arst no done", seen, 0);
    read_reg(3'd1, v);
    check("arst R1 not written", v, 16'h0);
    issue(16'h4061, lat);
    check("post latency", lat, 3);
    check("post d_out", d_out, 16'h0003);
    read_reg(3'd2, v);
    check("post R2", v, 16'h0003);
    leave_done("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
